// File: rtl/prog_rom_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_rom_if
// Brief    : Loader/fetch bus of the program ROM (program, read, status).
// Revision : 1.0 - initial release
// ============================================================================
interface prog_rom_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  rom_enable;
  logic                  prog_start;
  logic                  prog_valid;
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [DATA_WIDTH-1:0] prog_data;
  logic                  prog_done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   word_count;
  logic [DATA_WIDTH-1:0] checksum;
  logic                  err;

  modport master (
    output rom_enable, prog_start, prog_valid, prog_addr, prog_data, prog_done,
    output rd_en, rd_addr,
    input  rd_data, rd_valid, state, word_count, checksum, err
  );

  modport slave (
    input  rom_enable, prog_start, prog_valid, prog_addr, prog_data, prog_done,
    input  rd_en, rd_addr,
    output rd_data, rd_valid, state, word_count, checksum, err
  );
endinterface
`default_nettype wire

// File: rtl/prog_rom.sv
`default_nettype none
// ============================================================================
// Module   : prog_rom
// Brief    : Field-programmable program memory with load session, lock,
//            registered fetch port, word count, checksum and sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module prog_rom #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  wire logic clock,
  input  wire logic reset_n,
  prog_rom_if.slave bus
);

  localparam int                  c_depth     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_count_max = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] c_count_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_LOAD   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_wr_en;
  logic                  w_rd_fire;
  logic                  w_err_set;
  logic                  w_session_start;

  logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic [DATA_WIDTH-1:0] r_checksum;
  logic                  r_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A deasserted-high rom_enable gates every request, so nothing below fires.
  always_comb begin
    w_state_next    = r_state;
    w_wr_en         = 1'b0;
    w_rd_fire       = 1'b0;
    w_err_set       = 1'b0;
    w_session_start = 1'b0;
    if (!bus.rom_enable) begin
      case (r_state)
        ST_EMPTY: begin
          if (bus.prog_start) begin
            w_session_start = 1'b1;
            w_state_next    = ST_LOAD;
          end
          w_err_set = bus.rd_en | bus.prog_valid | bus.prog_done;
        end
        ST_LOAD: begin
          w_wr_en   = bus.prog_valid;
          w_err_set = bus.rd_en;
          if (bus.prog_done) begin
            w_state_next = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          w_rd_fire = bus.rd_en;
          w_err_set = bus.prog_valid;
          if (bus.prog_start) begin
            w_session_start = 1'b1;
            w_state_next    = ST_LOAD;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // The array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data <= r_mem[bus.rd_addr];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_word_count <= '0;
      r_checksum   <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_session_start) begin
        r_word_count <= '0;
        r_checksum   <= '0;
      end else if (w_wr_en) begin
        r_checksum <= r_checksum + bus.prog_data;
        if (r_word_count != c_count_max) begin
          r_word_count <= r_word_count + c_count_one;
        end
      end
      // An illegal access in the same cycle as a session start still flags.
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_session_start) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.rd_data    = r_rd_data;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.state      = r_state;
  assign bus.word_count = r_word_count;
  assign bus.checksum   = r_checksum;
  assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_rom
// Brief    : Randomised scoreboard bench for prog_rom with directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_rom;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  prog_rom_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  prog_rom #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [DW-1:0] d;
    bit            care;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad   = 0;

  // Reference model: memory contents plus the visible control status.
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  int            m_state = 0;
  int            m_cnt   = 0;
  logic [DW-1:0] m_sum   = '0;
  bit            m_err   = 1'b0;
  logic [DW-1:0] last_rd = '0;
  bit            last_known = 1'b1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit en_n, bit start, bit valid, logic [AW-1:0] a,
                            logic [DW-1:0] d, bit done, bit rd, logic [AW-1:0] ra);
    exp_t e;
    if (en_n) return;
    case (m_state)
      0: begin
        if (start) begin m_state = 1; m_cnt = 0; m_sum = '0; m_err = 1'b0; end
        if (rd || valid || done) m_err = 1'b1;
      end
      1: begin
        if (valid) begin
          m_mem[a] = d; m_known[a] = 1'b1;
          m_sum = m_sum + d;
          if (m_cnt < DEPTH) m_cnt++;
        end
        if (rd) m_err = 1'b1;
        if (done) m_state = 2;
      end
      default: begin
        if (rd) begin e.d = m_mem[ra]; e.care = m_known[ra]; q.push_back(e); end
        if (start) begin m_state = 1; m_cnt = 0; m_sum = '0; m_err = 1'b0; end
        if (valid) m_err = 1'b1;
      end
    endcase
  endtask

  // Called just after a rising edge; applies inputs for the next edge.
  task automatic drive(bit en_n, bit start, bit valid, logic [AW-1:0] a,
                       logic [DW-1:0] d, bit done, bit rd, logic [AW-1:0] ra);
    bus.rom_enable = en_n;
    bus.prog_start = start;
    bus.prog_valid = valid;
    bus.prog_addr  = a;
    bus.prog_data  = d;
    bus.prog_done  = done;
    bus.rd_en      = rd;
    bus.rd_addr    = ra;
    @(posedge clock);
    model_step(en_n, start, valid, a, d, done, rd, ra);
    #1;
    check("state", {30'd0, bus.state}, m_state);
    check("word_count", {27'd0, bus.word_count}, m_cnt);
    check("checksum", {24'd0, bus.checksum}, {24'd0, m_sum});
    check("err", {31'd0, bus.err}, {31'd0, m_err});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // Asserts reset mid-cycle and verifies outputs clear before any clock edge.
  task automatic async_reset(string tag);
    #1;
    reset_n = 1'b0;
    #1;
    check({tag, "_state"}, {30'd0, bus.state}, 0);
    check({tag, "_rd_valid"}, {31'd0, bus.rd_valid}, 0);
    check({tag, "_rd_data"}, {24'd0, bus.rd_data}, 0);
    check({tag, "_word_count"}, {27'd0, bus.word_count}, 0);
    check({tag, "_checksum"}, {24'd0, bus.checksum}, 0);
    check({tag, "_err"}, {31'd0, bus.err}, 0);
    q.delete();
    m_state = 0; m_cnt = 0; m_sum = '0; m_err = 1'b0;
    last_rd = '0; last_known = 1'b1;
    bus.rom_enable = 1'b0; bus.prog_start = 1'b0; bus.prog_valid = 1'b0;
    bus.prog_done = 1'b0; bus.rd_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Monitor: every cycle, rd_valid must match whether a read was expected.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          check("rd_valid_hi", {31'd0, bus.rd_valid}, 1);
          if (e.care) begin
            check("rd_data", {24'd0, bus.rd_data}, {24'd0, e.d});
            last_rd = e.d; last_known = 1'b1;
          end else begin
            last_known = 1'b0;
          end
        end else begin
          check("rd_valid_lo", {31'd0, bus.rd_valid}, 0);
          if (last_known) check("rd_hold", {24'd0, bus.rd_data}, {24'd0, last_rd});
        end
      end
    end
  end

  initial begin
    int r;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    bus.rom_enable = 1'b0; bus.prog_start = 1'b0; bus.prog_valid = 1'b0;
    bus.prog_addr = '0; bus.prog_data = '0; bus.prog_done = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    #2;
    check("rst_state", {30'd0, bus.state}, 0);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 0);
    check("rst_rd_data", {24'd0, bus.rd_data}, 0);
    check("rst_word_count", {27'd0, bus.word_count}, 0);
    check("rst_checksum", {24'd0, bus.checksum}, 0);
    check("rst_err", {31'd0, bus.err}, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Read while EMPTY is illegal.
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd3);
    check("empty_read_err", {31'd0, bus.err}, 1);
    check("empty_read_valid", {31'd0, bus.rd_valid}, 0);
    idle();

    // Full load and back-to-back readback.
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    check("start_err_clr", {31'd0, bus.err}, 0);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
    check("full_state", {30'd0, bus.state}, 2);
    check("full_count", {27'd0, bus.word_count}, 16);
    check("full_checksum", {24'd0, bus.checksum}, 32'h78);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'(i));
    idle();
    idle();

    // Same-cycle write and done.
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 4'd7, 8'h3C, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 4'd5, 8'hA5, 1'b1, 1'b0, '0);
    check("wd_state", {30'd0, bus.state}, 2);
    check("wd_count", {27'd0, bus.word_count}, 2);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd5);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd7);
    idle();

    // Write while locked, then re-open a session.
    drive(1'b0, 1'b0, 1'b1, 4'd2, 8'hFF, 1'b0, 1'b0, '0);
    check("locked_wr_err", {31'd0, bus.err}, 1);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd2);
    idle();
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    check("reload_state", {30'd0, bus.state}, 1);
    check("reload_err", {31'd0, bus.err}, 0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);

    // Chip select high freezes everything.
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd1);
    check("cs_rd_valid", {31'd0, bus.rd_valid}, 0);
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b1, 4'd4, 8'h55, 1'b0, 1'b0, '0);
    check("cs_count", {27'd0, bus.word_count}, 0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);

    // Random traffic, one request per cycle plus the write+done combination.
    for (int n = 0; n < 400; n++) begin
      bit en_n;
      en_n = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 19);
      if (r == 0)
        drive(en_n, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      else if (r <= 8)
        drive(en_n, 1'b0, 1'b1, 4'($urandom), 8'($urandom), 1'b0, 1'b0, '0);
      else if (r == 9)
        drive(en_n, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
      else if (r == 10)
        drive(en_n, 1'b0, 1'b1, 4'($urandom), 8'($urandom), 1'b1, 1'b0, '0);
      else if (r <= 17)
        drive(en_n, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'($urandom));
      else
        drive(en_n, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    end
    idle();
    idle();

    // Reset in the middle of a load session.
    async_reset("rst_a");
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 4'(i), 8'(8'h40 + i), 1'b0, 1'b0, '0);
    check("midload_count", {27'd0, bus.word_count}, 3);
    async_reset("midload");

    // Reset while a fetch result is being presented.
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 4'd9, 8'hC3, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd9);
    check("pre_rst_valid", {31'd0, bus.rd_valid}, 1);
    check("pre_rst_data", {24'd0, bus.rd_data}, 32'hC3);
    async_reset("rdv");
    idle();

    if (q.size() != 0) check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_rom.md
# prog_rom

Parametrised, field-programmable program memory for the 8-bit 5-stage core. It replaces the fixed-size ROM with a width/depth-generic array and adds several features: a load session that fills the array, a lock that blocks further writes, a registered fetch port with a valid strobe, a running word count and checksum, and a sticky error flag for illegal accesses. It sits between the boot/loader logic (program side) and the instruction-fetch stage (read side).

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, address width; DEPTH = 1 << ADDR_WIDTH words
- clock  in  1  single system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rom_enable  in  1  active-low chip select; high = block ignores all requests, state frozen
- prog_start  in  1  opens a load session
- prog_valid  in  1  write strobe for prog_addr/prog_data
- prog_addr  in  ADDR_WIDTH  write address
- prog_data  in  DATA_WIDTH  write data
- prog_done  in  1  closes load session, locks array
- rd_en  in  1  fetch request
- rd_addr  in  ADDR_WIDTH  fetch address
- rd_data  out  DATA_WIDTH  registered fetch data
- rd_valid  out  1  one-cycle strobe, rd_data is valid
- state  out  2  00 EMPTY, 01 LOAD, 10 LOCKED
- word_count  out  ADDR_WIDTH+1  accepted writes this session, saturates at DEPTH
- checksum  out  DATA_WIDTH  sum of written data mod 2^DATA_WIDTH this session
- err  out  1  sticky illegal-access flag

## Operation
- All requests below are qualified by rom_enable == 0; with rom_enable == 1 nothing changes except rd_valid, which drops to 0.
- The state machine has three states.
  - EMPTY: prog_start -> LOAD. rd_en -> err = 1, no read. prog_valid/prog_done -> err = 1, ignored.
  - LOAD: on entry (the prog_start edge), word_count = 0, checksum = 0, err = 0.
    - prog_valid: mem[prog_addr] <= prog_data, checksum += prog_data, word_count += 1 (saturating at DEPTH; rewriting an address still counts).
    - prog_done -> LOCKED. If prog_valid is asserted in the same cycle, the write, count and checksum complete first.
    - prog_start is ignored.
    - rd_en -> err = 1, no read.
  - LOCKED: rd_en -> read mem[rd_addr]. prog_valid -> err = 1, array unchanged. prog_start -> LOAD (re-program; the array keeps its old contents until overwritten). prog_done is ignored.
- Array contents are not cleared by reset; only the control state resets.
- err is set by any illegal access listed above. It is cleared only by reset_n or an accepted prog_start.

## Timing
- Reset (reset_n low, asynchronous) forces these outputs:
  - state = EMPTY
  - rd_data = 0, rd_valid = 0
  - word_count = 0, checksum = 0
  - err = 0
- Read latency is 1 cycle. For a request sampled at edge N, rd_data and rd_valid = 1 update at edge N. They are visible during cycle N..N+1, and rd_valid drops at edge N+1 unless a new request is sampled.
- Back-to-back reads run one per cycle, fully pipelined.
- rd_data holds its last value while rd_valid = 0.
- A write sampled at edge N is readable by a fetch sampled at edge N+1 or later. This requires the array to be LOCKED first, so the earliest read is one edge after the prog_done edge.
- state, word_count, checksum and err all update on the same edge as the triggering request.
- If reset_n asserts during LOAD, the session is aborted: state = EMPTY, and any partially written words stay in the array but are unreachable until the next session locks.
- If reset_n asserts while rd_valid = 1, rd_valid is forced to 0 immediately.

## Test plan
- Reset then read: release reset_n, assert rd_en with rd_addr = 3 -> rd_valid stays 0, err = 1, state = 00.
- Full load and readback (ADDR_WIDTH = 4):
  - Stimulus: prog_start, then write addr i with data 8'h10+i for i = 0..15, then prog_done.
  - Required: state = 10, word_count = 16, checksum = 8'h78.
  - Then reads of 0..15 back-to-back -> rd_data = 8'h10..8'h1F, with rd_valid high for 16 consecutive cycles, one edge after each request.
- Same-cycle write and done: in LOAD, prog_valid with addr 5, data 8'hA5 together with prog_done -> state = 10, mem[5] = 8'hA5 on readback, word_count includes that write.
- Write while locked: in LOCKED, prog_valid with addr 2, data 8'hFF -> err = 1 and a later read of addr 2 returns the original value. A following prog_start -> err = 0, word_count = 0, checksum = 0, state = 01.
- Chip select: in LOCKED with rom_enable = 1, rd_en on addr 1 -> rd_valid = 0, err unchanged. With rom_enable = 1 in LOAD, prog_valid -> word_count unchanged.
- Reset mid-load: assert reset_n low after 3 writes -> state = 00, word_count = 0, checksum = 0 asynchronously, without waiting for a clock edge.
